led_framebuffer: RTL

Double-buffered 64x64 RGB888 frame store that sits directly upstream of the HUB75 scan engine, replacing the static sprite ROM as its pixel source. A producer streams pixels in raster order over a valid/ready port into the back bank. The scanner reads both panel halves (row y and row y+32) in one registered lookup from the front bank. Banks swap only on a scanner frame boundary, so a frame is never displayed half-written.

---
 rtl/led_framebuffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/led_framebuffer.sv
// led_framebuffer: double-buffered RGB frame store feeding the HUB75 scanner.
// Producer fills the back bank in raster order; banks swap on vsync once full.
module led_framebuffer #(
  parameter int C_BITS = 8,
  parameter int COLS   = 64,
  parameter int ROWS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [3*C_BITS-1:0]   in_data,
  input  logic                  vsync,
  input  logic [6:0]            rd_addrx,
  input  logic [4:0]            rd_addry,
  output logic [C_BITS-1:0]     r0,
  output logic [C_BITS-1:0]     g0,
  output logic [C_BITS-1:0]     b0,
  output logic [C_BITS-1:0]     r1,
  output logic [C_BITS-1:0]     g1,
  output logic [C_BITS-1:0]     b1,
  output logic                  front_bank,
  output logic                  frame_pending,
  output logic                  err_resync
);

  localparam int PW    = 3 * C_BITS;
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int HW    = XW + YW;
  localparam int WPW   = HW + 1;
  localparam int DEPTH = 2 * ROWS * COLS;

  localparam logic [WPW-1:0] WP_LAST = {WPW{1'b1}};
  localparam logic [WPW-1:0] WP_ONE  = WPW'(1);
  localparam logic [6:0]     COLS_X  = 7'(COLS);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [WPW-1:0] wp_q, wp_d;
  logic           front_q, front_d;
  logic           err_q, err_d;

  logic           we;
  logic [WPW-1:0] wa;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    front_d = front_q;
    err_d   = 1'b0;
    we      = 1'b0;
    wa      = wp_q;
    unique case (state_q)
      S_FILL: begin
        if (in_valid) begin
          we = 1'b1;
          if (in_sof) begin
            // sof always restarts the frame at the origin
            wa    = '0;
            wp_d  = WP_ONE;
            err_d = (wp_q != '0);
          end else begin
            wp_d = wp_q + WP_ONE;
            if (wp_q == WP_LAST) state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (vsync) begin
          front_d = ~front_q;
          wp_d    = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      wp_q    <= '0;
      front_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      front_q <= front_d;
      err_q   <= err_d;
    end
  end

  assign in_ready      = (state_q == S_FILL);
  assign frame_pending = (state_q == S_FULL);
  assign front_bank    = front_q;
  assign err_resync    = err_q;

  // One RAM per panel half; the bank is the top address bit.
  logic [PW-1:0] mem_u [DEPTH];
  logic [PW-1:0] mem_l [DEPTH];

  logic [HW:0] wr_a;
  assign wr_a = {~front_q, wa[HW-1:0]};

  always_ff @(posedge clk) begin
    if (we && !wa[WPW-1]) mem_u[wr_a] <= in_data;
    if (we &&  wa[WPW-1]) mem_l[wr_a] <= in_data;
  end

  logic [HW:0] rd_a;
  logic        blank;
  logic [PW-1:0] up_q, lo_q;

  assign rd_a  = {front_q, rd_addry[YW-1:0], rd_addrx[XW-1:0]};
  assign blank = (rd_addrx >= COLS_X);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q <= '0;
      lo_q <= '0;
    end else if (blank) begin
      up_q <= '0;
      lo_q <= '0;
    end else begin
      up_q <= mem_u[rd_a];
      lo_q <= mem_l[rd_a];
    end
  end

  assign r0 = up_q[PW-1 -: C_BITS];
  assign g0 = up_q[2*C_BITS-1 -: C_BITS];
  assign b0 = up_q[C_BITS-1:0];
  assign r1 = lo_q[PW-1 -: C_BITS];
  assign g1 = lo_q[2*C_BITS-1 -: C_BITS];
  assign b1 = lo_q[C_BITS-1:0];

endmodule
